trigger_event_capture: RTL
==========================

Name: trigger_event_capture

Overview:
- Collects single-cycle event pulses produced by fabric logic (count-equals flags, terminal counts) into sticky pending bits, so that no event is lost between host polls.
- Delivers a consistent snapshot to the host-facing side through a four-phase req/ack handshake.
- This is the fabric-to-host direction, the counterpart of the host-to-fabric trigger path.
- Sits between application counters and the host trigger/wire-out endpoints, all on sys_clk.

Parameters:
WIDTH, 16, number of event channels.
EDGE, 0, 0 = every cycle with ev_in[i]=1 is an event; 1 = only a 0->1 transition of ev_in[i] is an event.
MISS_W, 8, width of the saturating missed-event counter.

Ports:
sys_clk  input  1  system clock; all logic is on its rising edge.
reset_n  input  1  asynchronous, active-low reset.
ev_in  input  WIDTH  event sources, synchronous to sys_clk.
snap_req  input  1  host-side snapshot request (level, four-phase).
snap_ack  output  1  snapshot-complete acknowledge (level, four-phase).
snap_data  output  WIDTH  last captured event set; stable between captures.
pending  output  WIDTH  current sticky event bits.
any_pending  output  1  OR-reduction of pending (combinational from the pending register).
miss_clr  input  1  single-cycle pulse that clears miss_count.
miss_count  output  MISS_W  saturating count of cycles in which an event hit an already-pending bit.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - pending=0, snap_data=0, snap_ack=0, miss_count=0, edge history=0, FSM=IDLE.
  - Reset mid-handshake drops snap_ack immediately and discards pending.
- Event detect, per bit:
  - EDGE=0: ev[i] = ev_in[i].
  - EDGE=1: ev[i] = ev_in[i] & ~prev[i], where prev is a register of ev_in.
  - Detected events are visible in pending on the same rising edge.
- Pending update outside CAPTURE: pending <= pending | ev.
- Miss detect: hit = |(pending & ev).
  - miss_count increments by 1 per cycle with hit=1, regardless of how many bits collide.
  - Saturates at all-ones.
- miss_clr: miss_count <= 0. If miss_clr and hit occur in the same cycle, miss_count <= 1.
- FSM states: IDLE, CAPTURE, ACK.
  - IDLE: snap_ack=0. When snap_req=1 is sampled -> CAPTURE.
  - CAPTURE (exactly one cycle):
    - snap_data <= pending | ev, so events arriving in the capture cycle are included.
    - pending <= 0.
    - snap_ack <= 1; -> ACK.
    - No bit is both captured and left pending, and none is dropped.
    - Miss detection still applies in this cycle against the old pending value.
  - ACK: snap_ack held 1; snap_data frozen; pending accumulates normally.
    - When snap_req=0 is sampled: snap_ack <= 0, -> IDLE.
  - Latency: snap_req rising, sampled at edge k -> snap_data valid and snap_ack=1 after edge k+1.
  - A req still high when returning to IDLE is impossible by protocol. Since IDLE is entered only on req=0, snap_req re-asserted the cycle after ack falls starts a new capture.
- No events are ever lost except through the miss path: a bit already pending absorbs repeats, which are counted as misses.
- Registered outputs: snap_ack, snap_data, pending, miss_count. any_pending is combinational from pending only; there is no ev_in-to-output combinational path.

Test Plan:
- Reset/idle: release reset_n with ev_in=0 -> pending=0, any_pending=0, snap_ack=0, snap_data=0, miss_count=0.
- Basic capture (EDGE=0):
  - Stimulus: pulse ev_in=16'h0001 for 1 cycle, then 16'h0080 for 1 cycle; raise snap_req.
  - Required: 2 edges later snap_ack=1, snap_data=16'h0081, pending=0.
  - Required: drop snap_req -> snap_ack=0 one edge later.
- Capture-cycle collision:
  - Stimulus: ev_in=16'h0004 during the CAPTURE cycle, ev_in=16'h0010 during ACK.
  - Required: snap_data includes 16'h0004; after ACK, pending=16'h0010.
- Miss counting:
  - Stimulus: ev_in=16'h0002 held for 5 cycles with EDGE=0 -> miss_count=4; with EDGE=1 -> miss_count=0 and pending=16'h0002.
  - Stimulus: force 300 misses with MISS_W=8 -> miss_count=8'hFF.
  - Stimulus: miss_clr coincident with a miss -> miss_count=1.
- Reset mid-handshake:
  - Stimulus: assert reset_n=0 while in ACK with pending=16'h00F0.
  - Required: snap_ack=0 and pending=0 immediately (asynchronously); after release, a new snap_req completes normally with snap_data=0.

Source files
------------

// File: rtl/trigger_event_capture.sv
// trigger_event_capture: collects single-cycle fabric event pulses into sticky
// pending bits and hands a consistent snapshot to the host side through a
// four-phase snap_req/snap_ack handshake. Repeated events on a bit that is
// already pending are counted in a saturating miss counter.
module trigger_event_capture #(
  parameter int WIDTH  = 16,
  parameter int EDGE   = 0,
  parameter int MISS_W = 8
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  ev_in,
  input  logic              snap_req,
  output logic              snap_ack,
  output logic [WIDTH-1:0]  snap_data,
  output logic [WIDTH-1:0]  pending,
  output logic              any_pending,
  input  logic              miss_clr,
  output logic [MISS_W-1:0] miss_count
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_ACK     = 2'd2;

  localparam logic [MISS_W-1:0] MISS_ONE = {{(MISS_W-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [WIDTH-1:0] ev_in_p0;
  logic [WIDTH-1:0] ev;
  logic             hit;

  // Saturating increment: holds at all-ones instead of wrapping to zero.
  function automatic logic [MISS_W-1:0] sat_inc(input logic [MISS_W-1:0] v);
    if (&v) return v;
    return v + MISS_ONE;
  endfunction

  // Event detect: level mode passes ev_in through, edge mode keeps only 0->1.
  always_comb begin
    ev = ev_in;
    if (EDGE != 0) ev = ev_in & ~ev_in_p0;
  end

  assign hit         = |(pending & ev);
  assign any_pending = |pending;

  // Edge history register for rising-edge detection.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) ev_in_p0 <= '0;
    else          ev_in_p0 <= ev_in;
  end

  // Miss counter: one count per colliding cycle; a clear coincident with a
  // miss leaves that miss counted.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n)      miss_count <= '0;
    else if (miss_clr) miss_count <= hit ? MISS_ONE : '0;
    else if (hit)      miss_count <= sat_inc(miss_count);
  end

  // Handshake FSM with pending accumulation; the capture cycle moves
  // pending|ev into snap_data so no bit is both captured and left pending.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      snap_ack  <= 1'b0;
      snap_data <= '0;
      pending   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          snap_ack <= 1'b0;
          pending  <= pending | ev;
          if (snap_req) state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          snap_data <= pending | ev;
          pending   <= '0;
          snap_ack  <= 1'b1;
          state     <= S_ACK;
        end
        S_ACK: begin
          pending <= pending | ev;
          if (!snap_req) begin
            snap_ack <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: begin
          snap_ack <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
